// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues ops to a fixed-latency ALU and returns tagged, in-order responses.
// Optional perf counters are built when ALU_ISSUER_PERF_EN is defined.
module alu_cmd_issuer #(
  parameter int W         = 64,
  parameter int TAG_W     = 4,
  parameter int ALU_LAT   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_opcode_i,
  input  logic [W-1:0]     req_a_i,
  input  logic [W-1:0]     req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [3:0]       alu_opcode_o,
  output logic [W-1:0]     alu_input1_o,
  output logic [W-1:0]     alu_input2_o,
  output logic [4:0]       alu_shift_o,
  input  logic [W-1:0]     alu_result_i,
  input  logic             alu_carry_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [W-1:0]     rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
  output logic             rsp_sign_o,
  output logic             rsp_err_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      perf_issued_o,
  output logic [31:0]      perf_stall_o
);

  localparam int NS = ALU_LAT + 1;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + NS + 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd6;

  typedef struct packed {
    logic             carry;
    logic             zero;
    logic             sign;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     res;
  } rsp_t;

  logic             accept;
  logic             pop;
  logic             push;
  logic             req_illegal;

  logic             slot_v_q   [NS];
  logic [TAG_W-1:0] slot_tag_q [NS];
  logic [3:0]       slot_op_q  [NS];
  logic             slot_err_q [NS];

  rsp_t             fifo_q [RSP_DEPTH];
  rsp_t             cap;
  rsp_t             head;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    outst;
  logic             cap_arith;

  assign req_illegal = req_opcode_i > OP_PASSB;
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_valid_o = cnt_q != '0;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = slot_v_q[NS-1];
  assign alu_shift_o = 5'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode_o <= '0;
      alu_input1_o <= '0;
      alu_input2_o <= '0;
    end else if (accept) begin
      alu_opcode_o <= req_opcode_i;
      alu_input1_o <= req_a_i;
      alu_input2_o <= req_b_i;
    end
  end

  // One slot per ALU stage plus one; the last slot lines up with a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        slot_v_q[i]   <= 1'b0;
        slot_tag_q[i] <= '0;
        slot_op_q[i]  <= '0;
        slot_err_q[i] <= 1'b0;
      end
    end else begin
      slot_v_q[0]   <= accept;
      slot_tag_q[0] <= req_tag_i;
      slot_op_q[0]  <= req_opcode_i;
      slot_err_q[0] <= req_illegal;
      for (int i = 1; i < NS; i++) begin
        slot_v_q[i]   <= slot_v_q[i-1];
        slot_tag_q[i] <= slot_tag_q[i-1];
        slot_op_q[i]  <= slot_op_q[i-1];
        slot_err_q[i] <= slot_err_q[i-1];
      end
    end
  end

  always_comb begin
    cap_arith = (slot_op_q[NS-1] == OP_ADD) |
                (slot_op_q[NS-1] == OP_SUB);
    cap       = '0;
    cap.err   = slot_err_q[NS-1];
    cap.tag   = slot_tag_q[NS-1];
    cap.res   = slot_err_q[NS-1] ? '0 : alu_result_i;
    cap.carry = alu_carry_i & cap_arith;
    cap.zero  = cap.res == '0;
    cap.sign  = cap.res[W-1];
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    unique case (1'b1)
      (push & ~pop): cnt_d = cnt_q + 1'b1;
      (pop & ~push): cnt_d = cnt_q - 1'b1;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= cap;
    end
  end

  assign head         = fifo_q[rptr_q];
  assign rsp_result_o = head.res;
  assign rsp_carry_o  = head.carry;
  assign rsp_zero_o   = head.zero;
  assign rsp_sign_o   = head.sign;
  assign rsp_err_o    = head.err;
  assign rsp_tag_o    = head.tag;

  // A pop this cycle frees its entry at the same edge, so its credit is reusable now.
  always_comb begin
    outst = OW'(cnt_q);
    for (int i = 0; i < NS; i++) begin
      outst = outst + OW'(slot_v_q[i]);
    end
  end

  assign req_ready_o = (outst - OW'(pop)) < OW'(RSP_DEPTH);

`ifdef ALU_ISSUER_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;
  logic        stall;

  assign stall = req_valid_i & ~req_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (accept && issued_q != 32'hFFFF_FFFF) begin
        issued_q <= issued_q + 32'd1;
      end
      if (stall && stall_q != 32'hFFFF_FFFF) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
`else
  assign perf_issued_o = 32'd0;
  assign perf_stall_o  = 32'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench with a 2-stage behavioural ALU behind the issuer.
module tb_alu_cmd_issuer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_input1, alu_input2;
  logic [4:0]  alu_shift;
  logic [63:0] alu_result;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_sign, rsp_err;
  logic [3:0]  rsp_tag;
  logic [31:0] perf_issued, perf_stall;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opcode_i(req_opcode), .req_a_i(req_a),
    .req_b_i(req_b), .req_tag_i(req_tag),
    .alu_opcode_o(alu_opcode), .alu_input1_o(alu_input1),
    .alu_input2_o(alu_input2), .alu_shift_o(alu_shift),
    .alu_result_i(alu_result), .alu_carry_i(alu_carry),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_carry_o(rsp_carry),
    .rsp_zero_o(rsp_zero), .rsp_sign_o(rsp_sign),
    .rsp_err_o(rsp_err), .rsp_tag_o(rsp_tag),
    .perf_issued_o(perf_issued), .perf_stall_o(perf_stall)
  );

  // Behavioural ALU: two register stages; carry is junk (1) for non-arith ops.
  function automatic logic [64:0] alu_f(input logic [3:0] op,
                                        input logic [63:0] a, b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {(a < b), a - b};
      4'd2:    return {1'b1, a * b};
      4'd3:    return {1'b1, ~(a & b)};
      4'd4:    return {1'b1, a & b};
      4'd5:    return {1'b1, a | b};
      4'd6:    return {1'b1, b};
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  logic [64:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= alu_f(alu_opcode, alu_input1, alu_input2);
    s2 <= s1;
  end
  assign alu_result = s2[63:0];
  assign alu_carry  = s2[64];

  task automatic issue(input logic [3:0] op, input logic [63:0] a, b,
                       input logic [3:0] tag);
    int n = 0;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready tag=%0d got=%b want=1", tag, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({rsp_valid, alu_opcode, alu_input1, alu_input2, alu_shift} !== '0) begin
      fails++;
      $display("FAIL reset_outs got v=%b op=%h a=%h b=%h sh=%h want all 0",
               rsp_valid, alu_opcode, alu_input1, alu_input2, alu_shift);
    end
    tests++;
    if ({perf_issued, perf_stall} !== 64'd0) begin
      fails++;
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_issued, perf_stall);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_add_carry();
    rsp_ready = 1'b1;
    issue(4'd0, ONES, 64'd1, 4'd3);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL add_early cycle=%0d got=%b want=0", i + 1, rsp_valid);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL add_latency got=%b want=1", rsp_valid);
    end
    tests++;
    if ({rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag} !==
        {64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3}) begin
      fails++;
      $display("FAIL add_fields got r=%h c%b z%b s%b e%b t%0d want r=0 c1 z1 s0 e0 t3",
               rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_pop got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_sub_borrow();
    int n;
    issue(4'd1, 64'd0, 64'd1, 4'd5);
    wait_rsp(n);
    tests++;
    if (rsp_valid !== 1'b1 ||
        {rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag} !==
        {ONES, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5}) begin
      fails++;
      $display("FAIL sub_fields got v%b r=%h c%b z%b s%b e%b t%0d want r=all1 c1 z0 s1 e0 t5",
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_mask();
    int n;
    issue(4'd0, ONES, 64'd2, 4'd6);
    issue(4'd3, 64'd0, 64'd0, 4'd7);
    wait_rsp(n);
    tests++;
    if (rsp_valid !== 1'b1 ||
        {rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag} !==
        {64'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6}) begin
      fails++;
      $display("FAIL mask_add got v%b r=%h c%b z%b s%b t%0d want r=1 c1 z0 s0 t6",
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_tag);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 ||
        {rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag} !==
        {ONES, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7}) begin
      fails++;
      $display("FAIL mask_nand got v%b r=%h c%b z%b s%b t%0d want r=all1 c0 z0 s1 t7",
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int last  = 0;
    int extra = 0;
    rsp_ready  = 1'b0;
    req_opcode = 4'd2; req_a = 64'd3; req_b = 64'd5;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(i);
      tests++;
      if (req_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_credit idx=%0d got=%b want=1", i, req_ready);
      end
      @(posedge clk); #1;
    end
    req_tag = 4'd4;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full got=%b want=0", req_ready);
    end
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if ({req_ready, rsp_valid} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_hold got rdy=%b v=%b want rdy=0 v=1", req_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    #1;
    fork
      begin
        for (int t = 4; t < 8; t++) issue(4'd2, 64'd3, 64'd5, 4'(t));
      end
      begin
        for (int j = 0; j < 8; j++) begin
          int n;
          wait_rsp(n);
          if (j == 0) first = cyc;
          last = cyc;
          tests++;
          if (rsp_valid !== 1'b1 || rsp_tag !== 4'(j) ||
              rsp_result !== 64'd15 || rsp_carry !== 1'b0) begin
            fails++;
            $display("FAIL b2b_rsp idx=%0d got v%b t%0d r=%0d c%b want v1 t%0d r=15 c0",
                     j, rsp_valid, rsp_tag, rsp_result, rsp_carry, j);
          end
          @(posedge clk); #1;
        end
      end
    join
    tests++;
    if (last - first !== 7) begin
      fails++;
      $display("FAIL b2b_rate got span=%0d want 7", last - first);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL b2b_dup got extra=%0d want 0", extra);
    end
  endtask

  task automatic test_illegal();
    int n;
    rsp_ready = 1'b1;
    issue(4'hF, 64'd7, 64'd9, 4'd9);
    wait_rsp(n);
    tests++;
    if (rsp_valid !== 1'b1 ||
        {rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag} !==
        {64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9}) begin
      fails++;
      $display("FAIL illegal got v%b r=%h c%b z%b s%b e%b t%0d want r=0 c0 z1 s0 e1 t9",
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    logic [31:0] exp_i, exp_s;
    rsp_ready = 1'b0;
    issue(4'd4, 64'hF0, 64'h3C, 4'd1);
    issue(4'd5, 64'hF0, 64'h0F, 4'd2);
    repeat (4) begin @(posedge clk); #1; end
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_buffered got=%b want=1", rsp_valid);
    end
    issue(4'd6, 64'd0, 64'd11, 4'd3);
    issue(4'd0, 64'd1, 64'd1, 4'd4);
    rst = 1'b1;
    #1;
    tests++;
    if ({rsp_valid, perf_issued, perf_stall} !== 65'd0) begin
      fails++;
      $display("FAIL mid_rst got v=%b pi=%0d ps=%0d want 0/0/0",
               rsp_valid, perf_issued, perf_stall);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) stale++;
    end
    tests++;
    if (stale !== 0) begin
      fails++;
      $display("FAIL mid_stale got=%0d want 0", stale);
    end
    rsp_ready  = 1'b0;
    req_opcode = 4'd0; req_a = 64'd2; req_b = 64'd2; req_tag = 4'd0;
    req_valid  = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    req_valid = 1'b0;
`ifdef ALU_ISSUER_PERF_EN
    exp_i = 32'd4; exp_s = 32'd3;
`else
    exp_i = 32'd0; exp_s = 32'd0;
`endif
    tests++;
    if (perf_issued !== exp_i || perf_stall !== exp_s) begin
      fails++;
      $display("FAIL perf got issued=%0d stall=%0d want %0d/%0d",
               perf_issued, perf_stall, exp_i, exp_s);
    end
    rsp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL drain got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_carry_mask();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
